// File: rtl/bch_encode_serial_pkg.sv
// -----------------------------------------------------------------------------
// bch_encode_serial_pkg
// Shared BCH definitions for the encoder and the decoder chain.
//   - Default BCH(31,16), T=3 constants (M=5, primitive polynomial x^5+x^2+1).
//   - Encoder FSM state type.
//   - bch_generator(m, t): builds g(x) as the product of (x + alpha^k) over every
//     k in the cyclotomic cosets of 1..2t, so that encoder and decoder derive
//     GENERATOR identically from (M, T).
//   - bch_ecc_bits(m, t): degree of that generator (ECC_BITS).
// Both functions are elaboration-time helpers and support m = 3..10.
// -----------------------------------------------------------------------------
package bch_encode_serial_pkg;

  localparam int          BCH_DEFAULT_M         = 5;
  localparam int          BCH_DEFAULT_T         = 3;
  localparam int          BCH_DEFAULT_DATA_BITS = 16;
  localparam int          BCH_DEFAULT_ECC_BITS  = 15;
  localparam logic [15:0] BCH_DEFAULT_GENERATOR = 16'h8FAF;

  typedef enum logic {
    ST_DATA   = 1'b0,
    ST_PARITY = 1'b1
  } enc_state_t;

  // Primitive polynomial of GF(2^m), bit i = coefficient of x^i.
  function automatic int bch_prim_poly(input int m);
    case (m)
      3:       return 'h00B;
      4:       return 'h013;
      5:       return 'h025;
      6:       return 'h043;
      7:       return 'h089;
      8:       return 'h11D;
      9:       return 'h211;
      10:      return 'h409;
      default: return 'h025;
    endcase
  endfunction

  // Multiply two GF(2^m) elements (shift-and-add with modular reduction).
  function automatic int bch_gf_mul(input int a, input int b, input int m, input int prim);
    int p;
    int x;
    p = 0;
    x = a;
    for (int i = 0; i < m; i++) begin
      if (((b >> i) & 1) != 0) p = p ^ x;
      x = x << 1;
      if (((x >> m) & 1) != 0) x = x ^ prim;
    end
    return p;
  endfunction

  function automatic logic [63:0] bch_generator(input int m, input int t);
    int          n;
    int          prim;
    int          j;
    int          a;
    bit          root [0:1023];
    int          c    [0:63];
    logic [63:0] g;
    n    = (1 << m) - 1;
    prim = bch_prim_poly(m);
    for (int k = 0; k < 1024; k++) root[k] = 1'b0;
    for (int k = 0; k < 64; k++) c[k] = 0;
    // Mark the conjugacy classes of alpha^1 .. alpha^2t.
    for (int i = 1; i <= 2 * t; i++) begin
      j = i % n;
      for (int k = 0; k < m; k++) begin
        root[j] = 1'b1;
        j = (j * 2) % n;
      end
    end
    // Multiply out prod (x + alpha^k); coefficients collapse to {0,1}.
    c[0] = 1;
    a    = 1;
    for (int k = 0; k < n; k++) begin
      if (root[k]) begin
        for (int d = 63; d > 0; d--) c[d] = c[d-1] ^ bch_gf_mul(c[d], a, m, prim);
        c[0] = bch_gf_mul(c[0], a, m, prim);
      end
      a = bch_gf_mul(a, 2, m, prim);
    end
    g = '0;
    for (int d = 0; d < 64; d++) g[d] = (c[d] & 1) != 0;
    return g;
  endfunction

  function automatic int bch_ecc_bits(input int m, input int t);
    logic [63:0] g;
    int          deg;
    g   = bch_generator(m, t);
    deg = 0;
    for (int d = 0; d < 64; d++) if (g[d]) deg = d;
    return deg;
  endfunction

endpackage

// File: rtl/bch_encode_serial_if.sv
// -----------------------------------------------------------------------------
// bch_encode_serial_if
// Bit-serial message input stream and codeword output stream of the encoder.
//   data_in/data_valid/data_ready : message bits, MSB (highest x power) first
//   code_out/code_valid/code_ready: codeword bits, data then parity
//   code_first / code_last        : first bit / last parity bit of a codeword
// Modports: slave = encoder side, master = source/sink side.
// -----------------------------------------------------------------------------
interface bch_encode_serial_if;
  logic data_in;
  logic data_valid;
  logic data_ready;
  logic code_out;
  logic code_valid;
  logic code_ready;
  logic code_first;
  logic code_last;

  modport slave (
    input  data_in, data_valid, code_ready,
    output data_ready, code_out, code_valid, code_first, code_last
  );

  modport master (
    output data_in, data_valid, code_ready,
    input  data_ready, code_out, code_valid, code_first, code_last
  );
endinterface

// File: rtl/bch_encode_serial_lfsr.sv
// -----------------------------------------------------------------------------
// bch_encode_lfsr
// ECC_BITS-wide polynomial division register for systematic BCH encoding.
//   clk, reset : clock, synchronous active-high clear
//   en         : advance the register this cycle
//   fb_sel     : 1 = divide (feedback = data_in ^ msb), 0 = plain shift-out
//   data_in    : message bit being divided in
//   shift_out  : current msb, i.e. next parity bit when shifting out
// After all message bits are divided in, the register holds r(x) with the
// x^(ECC_BITS-1) coefficient in the msb; ECC_BITS plain shifts empty it.
// -----------------------------------------------------------------------------
module bch_encode_lfsr #(
  parameter int                ECC_BITS  = 15,
  parameter logic [ECC_BITS:0] GENERATOR = 16'h8FAF
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic fb_sel,
  input  logic data_in,
  output logic shift_out
);

  logic [ECC_BITS-1:0] lfsr_reg;
  logic [ECC_BITS-1:0] lfsr_next;
  logic                fb;

  assign fb        = fb_sel & (data_in ^ lfsr_reg[ECC_BITS-1]);
  assign shift_out = lfsr_reg[ECC_BITS-1];

  // One tap per generator coefficient; x^ECC_BITS is implied by the feedback.
  genvar gi;
  generate
    for (gi = 0; gi < ECC_BITS; gi++) begin : g_tap
      if (gi == 0) begin : g_lsb
        assign lfsr_next[gi] = fb & GENERATOR[gi];
      end else begin : g_mid
        assign lfsr_next[gi] = lfsr_reg[gi-1] ^ (fb & GENERATOR[gi]);
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_reg <= '0;
    end else if (en) begin
      lfsr_reg <= lfsr_next;
    end
  end

endmodule

// File: rtl/bch_encode_serial.sv
// -----------------------------------------------------------------------------
// bch_encode_serial
// Bit-serial systematic BCH encoder. Passes DATA_BITS message bits through,
// then appends ECC_BITS parity bits r(x) = m(x)*x^ECC_BITS mod g(x), MSB first.
//   clk   : clock
//   reset : synchronous active-high reset (abandons any partial frame)
//   bus   : bch_encode_serial_if.slave (input bit stream, output code stream)
// All outputs are registered except data_ready, which is combinational from
// the output register state, code_ready and the FSM state.
// -----------------------------------------------------------------------------
module bch_encode_serial
  import bch_encode_serial_pkg::*;
#(
  parameter int                DATA_BITS = BCH_DEFAULT_DATA_BITS,
  parameter int                ECC_BITS  = BCH_DEFAULT_ECC_BITS,
  parameter logic [ECC_BITS:0] GENERATOR = BCH_DEFAULT_GENERATOR
) (
  input logic               clk,
  input logic               reset,
  bch_encode_serial_if.slave bus
);

  localparam int CNT_MAX = (DATA_BITS > ECC_BITS) ? DATA_BITS : ECC_BITS;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] ECC_LAST  = CNT_W'(ECC_BITS - 1);

  enc_state_t       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             code_out_reg;
  logic             code_valid_reg;
  logic             code_first_reg;
  logic             code_last_reg;

  logic adv;
  logic accept;
  logic parity_adv;
  logic lfsr_msb;

  // The output register may be loaded when it is empty or being drained.
  assign adv        = !code_valid_reg || bus.code_ready;
  assign accept     = bus.data_valid && bus.data_ready;
  assign parity_adv = (state_reg == ST_PARITY) && adv;

  assign bus.data_ready = (state_reg == ST_DATA) && adv;
  assign bus.code_out   = code_out_reg;
  assign bus.code_valid = code_valid_reg;
  assign bus.code_first = code_first_reg;
  assign bus.code_last  = code_last_reg;

  bch_encode_lfsr #(
    .ECC_BITS  (ECC_BITS),
    .GENERATOR (GENERATOR)
  ) u_lfsr (
    .clk       (clk),
    .reset     (reset),
    .en        (accept || parity_adv),
    .fb_sel    (state_reg == ST_DATA),
    .data_in   (bus.data_in),
    .shift_out (lfsr_msb)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_DATA;
      cnt_reg        <= '0;
      code_out_reg   <= 1'b0;
      code_valid_reg <= 1'b0;
      code_first_reg <= 1'b0;
      code_last_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_DATA: begin
          if (accept) begin
            code_out_reg   <= bus.data_in;
            code_valid_reg <= 1'b1;
            code_first_reg <= (cnt_reg == '0);
            code_last_reg  <= 1'b0;
            if (cnt_reg == DATA_LAST) begin
              state_reg <= ST_PARITY;
              cnt_reg   <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end else if (adv) begin
            // Source starved while the sink drained us: emit a bubble.
            code_valid_reg <= 1'b0;
          end
        end
        ST_PARITY: begin
          if (adv) begin
            code_out_reg   <= lfsr_msb;
            code_valid_reg <= 1'b1;
            code_first_reg <= 1'b0;
            code_last_reg  <= (cnt_reg == ECC_LAST);
            if (cnt_reg == ECC_LAST) begin
              // The division register has shifted itself back to zero here.
              state_reg <= ST_DATA;
              cnt_reg   <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        default: begin
          state_reg <= ST_DATA;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bch_encode_serial.sv
// -----------------------------------------------------------------------------
// tb_bch_encode_serial
// Directed and randomized-handshake bench for the BCH(31,16) serial encoder.
// -----------------------------------------------------------------------------
module tb_bch_encode_serial;

  localparam logic [15:0] GEN = 16'h8FAF;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bch_encode_serial_if bus();

  bch_encode_serial #(
    .DATA_BITS (16),
    .ECC_BITS  (15),
    .GENERATOR (16'h8FAF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_frames = 0;

  bit         in_q  [$];
  logic [2:0] exp_q [$];   // {code_out, code_first, code_last}

  bit          rnd_ready    = 1'b0;
  bit          rnd_gap      = 1'b0;
  bit          hold_pending = 1'b0;
  logic [2:0]  held;
  logic [30:0] got_word     = '0;
  int          n_out        = 0;
  int          first_out_cyc = -1;
  int          last_out_cyc  = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Remainder of a 31-bit polynomial modulo g(x), by long division.
  function automatic logic [14:0] rem31(input logic [30:0] w);
    logic [30:0] r;
    r = w;
    for (int i = 30; i >= 15; i--) begin
      if (r[i]) r = r ^ (31'(GEN) << (i - 15));
    end
    return r[14:0];
  endfunction

  task automatic drive();
    bus.data_valid = (in_q.size() != 0) && (!rnd_gap || ($urandom_range(0, 3) != 0));
    bus.data_in    = (in_q.size() != 0) ? in_q[0] : 1'b0;
    bus.code_ready = !rnd_ready || ($urandom_range(0, 1) == 1);
  endtask

  task automatic push_frame(input logic [15:0] m, input logic [14:0] parity);
    logic [30:0] word;
    word = {m, parity};
    for (int i = 15; i >= 0; i--) in_q.push_back(m[i]);
    for (int i = 0; i < 31; i++) exp_q.push_back({word[30-i], i == 0, i == 30});
    drive();
  endtask

  // One clock: sample at the falling edge, advance queues at the rising edge.
  task automatic cycle();
    bit         take_in;
    bit         take_out;
    logic [2:0] e;
    @(negedge clk);
    take_in  = bus.data_valid && bus.data_ready && !reset;
    take_out = bus.code_valid && bus.code_ready && !reset;
    if (hold_pending && !reset) begin
      check("hold_stable", {bus.code_out, bus.code_first, bus.code_last}, held);
    end
    hold_pending = !reset && bus.code_valid && !bus.code_ready;
    held = {bus.code_out, bus.code_first, bus.code_last};
    if (hold_pending) check("stall_ready", bus.data_ready, 1'b0);
    if (take_out) begin
      if (exp_q.size() == 0) begin
        check("extra_bit", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("code_bit", {bus.code_out, bus.code_first, bus.code_last}, e);
      end
      got_word = {got_word[29:0], bus.code_out};
      n_out++;
      if (first_out_cyc < 0) first_out_cyc = cyc;
      last_out_cyc = cyc;
      if (bus.code_last) begin
        n_frames++;
        $display("frame %0d done at cycle %0d codeword %h", n_frames, cyc, got_word);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (take_in) void'(in_q.pop_front());
    drive();
  endtask

  task automatic run(input int budget);
    for (int k = 0; k < budget && exp_q.size() != 0; k++) cycle();
    check("drain_out", exp_q.size(), 0);
    check("drain_in", in_q.size(), 0);
  endtask

  task automatic pulse_reset();
    in_q.delete();
    exp_q.delete();
    reset = 1'b1;
    drive();
    cycle();
    reset = 1'b0;
    hold_pending = 1'b0;
    check("rst_valid", bus.code_valid, 1'b0);
    check("rst_out", {bus.code_out, bus.code_first, bus.code_last}, 3'b000);
  endtask

  initial begin
    logic [15:0] m;
    bus.data_in    = 1'b0;
    bus.data_valid = 1'b0;
    bus.code_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    check("reset_valid", bus.code_valid, 1'b0);
    check("reset_out", bus.code_out, 1'b0);
    check("reset_first", bus.code_first, 1'b0);
    check("reset_last", bus.code_last, 1'b0);
    check("reset_ready", bus.data_ready, 1'b1);

    // m = 0: all-zero codeword
    push_frame(16'h0000, 15'h0000);
    run(200);
    check("m0_word", 32'(got_word), 32'h0);

    // m = 1: parity equals the low part of g(x)
    push_frame(16'h0001, 15'h0FAF);
    run(200);
    check("m1_word", 32'(got_word), 32'({16'h0001, 15'h0FAF}));

    // m = 2: parity is x * (g - x^15); full codeword divisible by g(x)
    push_frame(16'h0002, 15'h1F5E);
    run(200);
    check("m2_word", 32'(got_word), 32'({16'h0002, 15'h1F5E}));
    check("m2_syndrome", 32'(rem31(got_word)), 32'h0);

    // Back-to-back frames with no idle cycle
    n_out = 0;
    first_out_cyc = -1;
    push_frame(16'h0001, 15'h0FAF);
    push_frame(16'h0002, 15'h1F5E);
    run(300);
    check("b2b_count", n_out, 62);
    check("b2b_span", last_out_cyc - first_out_cyc, 61);
    check("b2b_word", 32'(got_word), 32'({16'h0002, 15'h1F5E}));

    // Random data, random source gaps and sink backpressure
    rnd_ready = 1'b1;
    rnd_gap   = 1'b1;
    for (int f = 0; f < 100; f++) begin
      m = 16'($urandom);
      push_frame(m, rem31({m, 15'b0}));
    end
    run(20000);
    rnd_ready = 1'b0;
    rnd_gap   = 1'b0;
    drive();

    // Reset while data bit 7 is on the output
    push_frame(16'hA5C3, rem31({16'hA5C3, 15'b0}));
    for (int k = 0; k < 100 && in_q.size() > 8; k++) cycle();
    check("rst_data_reached", in_q.size(), 8);
    pulse_reset();
    push_frame(16'h0001, 15'h0FAF);
    run(200);
    check("after_rst_data_word", 32'(got_word), 32'({16'h0001, 15'h0FAF}));

    // Reset while parity bit 3 is on the output
    n_out = 0;
    push_frame(16'hFFFF, rem31({16'hFFFF, 15'b0}));
    for (int k = 0; k < 100 && n_out < 19; k++) cycle();
    check("rst_parity_reached", n_out, 19);
    pulse_reset();
    push_frame(16'h0001, 15'h0FAF);
    run(200);
    check("after_rst_par_word", 32'(got_word), 32'({16'h0001, 15'h0FAF}));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
